// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: arbiter state encoding and sizing helpers shared by the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, SEND} arb_state_t;

    localparam int DATA_W_DEF = 8;

    function automatic int gnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, uart_tx and grant-status signals around the arbiter.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int GNT_W   = gnt_w(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic                      gnt_active;
    logic [GNT_W-1:0]          gnt_id;
    logic                      pkt_done;
    logic                      timeout;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ack, tx_valid, tx_data, gnt_active, gnt_id, pkt_done, timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ack, tx_valid, tx_data, gnt_active, gnt_id, pkt_done, timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: first set bit of req searching upward from ptr with wrap-around.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] j;

    // Scan from the farthest offset down so the closest hit to ptr wins.
    always_comb begin
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
    end

    assign found = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to force release of a grantee idle TIMEOUT_CYC cycles mid-packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int GNT_W   = gnt_w(NUM_REQ)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    arb_state_t         state;
    logic [GNT_W-1:0]   rr_ptr;
    logic [GNT_W-1:0]   gnt_id;
    logic [GNT_W-1:0]   pick_idx;
    logic [GNT_W-1:0]   next_ptr;
    logic               pick_found;
    logic               last_q;
    logic               tx_valid;
    logic               gnt_active;
    logic               pkt_done;
    logic [DATA_W-1:0]  tx_data;
    logic [DATA_W-1:0]  sel_data;
    logic [NUM_REQ-1:0] req_ack;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout;
`endif

    rr_pick #(.N(NUM_REQ), .W(GNT_W)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign next_ptr = (gnt_id == GNT_W'(NUM_REQ - 1)) ? '0 : gnt_id + GNT_W'(1);
    assign sel_data = bus.req_data[gnt_id*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_id     <= '0;
            gnt_active <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            req_ack    <= '0;
            pkt_done   <= 1'b0;
            last_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            req_ack  <= '0;
            pkt_done <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_id     <= pick_idx;
                        gnt_active <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.req_valid[gnt_id]) begin
                        tx_data  <= sel_data;
                        tx_valid <= 1'b1;
                        req_ack  <= NUM_REQ'(1) << gnt_id;
                        last_q   <= bus.req_last[gnt_id];
                        state    <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
                    end else if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout    <= 1'b1;
                        gnt_active <= 1'b0;
                        rr_ptr     <= next_ptr;
                        idle_cnt   <= '0;
                        state      <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
`endif
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        tx_valid <= 1'b0;
                        if (last_q) begin
                            pkt_done   <= 1'b1;
                            gnt_active <= 1'b0;
                            rr_ptr     <= next_ptr;
                            state      <= IDLE;
                        end else begin
                            state <= GRANT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ack    = req_ack;
    assign bus.tx_valid   = tx_valid;
    assign bus.tx_data    = tx_data;
    assign bus.gnt_active = gnt_active;
    assign bus.gnt_id     = gnt_id;
    assign bus.pkt_done   = pkt_done;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout    = timeout;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed packets with a scoreboard of expected uart_tx bytes.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int GW = 2;

    typedef struct packed {
        logic [GW-1:0] gid;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int xfers = 0;
    int ack_cnt[N] = '{default: 0};
    exp_t exp_q[$];
    logic [DW:0] rq[N][$];

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .GNT_W(GW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .GNT_W(GW)
`ifdef UART_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic load(input int id, input logic [DW-1:0] d, input logic last);
        rq[id].push_back({last, d});
    endtask

    task automatic expect_tx(input int id, input logic [DW-1:0] d, input logic last);
        exp_q.push_back('{gid: GW'(id), data: d, last: last});
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() != 0) || bus.gnt_active;
        for (int i = 0; i < N; i++) b |= (rq[i].size() != 0);
        return b;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (busy() && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, n < 200, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_valid"}, bus.tx_valid, 0);
        check({tag, "_tx_data"}, bus.tx_data, 0);
        check({tag, "_req_ack"}, bus.req_ack, 0);
        check({tag, "_gnt_active"}, bus.gnt_active, 0);
        check({tag, "_gnt_id"}, bus.gnt_id, 0);
        check({tag, "_pkt_done"}, bus.pkt_done, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
    endtask

    // Requester model: presents the head of each queue, retires it on ack.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (bus.req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                bus.req_valid[i]           = rq[i].size() > 0;
                bus.req_data[i*DW +: DW]   = (rq[i].size() > 0) ? rq[i][0][DW-1:0] : '0;
                bus.req_last[i]            = (rq[i].size() > 0) ? rq[i][0][DW] : 1'b0;
            end
        end
    end

    // Monitor: a byte transfers at the edge following a cycle with tx_valid && tx_ready.
    initial begin
        exp_t e;
        bit pend;
        logic pend_last;
        pend = 0;
        pend_last = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pend = 0;
                continue;
            end
            for (int i = 0; i < N; i++) if (bus.req_ack[i]) ack_cnt[i]++;
            if (|bus.req_ack) check("ack_onehot", $onehot(bus.req_ack), 1);
            if (pend) check("pkt_done", bus.pkt_done, pend_last);
            pend = 0;
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_tx: got 0x%0h from gnt %0d, expected no transfer", bus.tx_data, bus.gnt_id);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", bus.tx_data, e.data);
                    check("tx_gnt_id", bus.gnt_id, e.gid);
                    pend = 1;
                    pend_last = e.last;
                end
                xfers++;
            end
        end
    end

    initial begin
        int n;
        int a0;
        int x0;
        logic [DW-1:0] d;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        // single requester, 3-byte packet
        load(1, 8'h41, 0); load(1, 8'h42, 0); load(1, 8'h43, 1);
        expect_tx(1, 8'h41, 0); expect_tx(1, 8'h42, 0); expect_tx(1, 8'h43, 1);
        drain("single_drain");
        check("single_gnt_id", bus.gnt_id, 1);
        check("single_gnt_active", bus.gnt_active, 0);
        check("single_acks", ack_cnt[1], 3);

        // rr_ptr now 2: req2 beats req0
        load(0, 8'h01, 1); load(2, 8'h02, 1);
        expect_tx(2, 8'h02, 1); expect_tx(0, 8'h01, 1);
        drain("rrptr_drain");

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // contention from reset, then req0 + req3 with rr_ptr=3
        load(0, 8'h10, 0); load(0, 8'h11, 1); load(2, 8'h20, 0); load(2, 8'h21, 1);
        expect_tx(0, 8'h10, 0); expect_tx(0, 8'h11, 1); expect_tx(2, 8'h20, 0); expect_tx(2, 8'h21, 1);
        drain("cont_drain");
        load(0, 8'h30, 0); load(0, 8'h31, 1); load(3, 8'h50, 1);
        expect_tx(3, 8'h50, 1); expect_tx(0, 8'h30, 0); expect_tx(0, 8'h31, 1);
        drain("cont2_drain");

        // backpressure: tx_ready low for 10 cycles after tx_valid rises
        bus.tx_ready = 1'b0;
        a0 = ack_cnt[1];
        load(1, 8'h61, 0); load(1, 8'h62, 1);
        expect_tx(1, 8'h61, 0); expect_tx(1, 8'h62, 1);
        n = 0;
        while (!bus.tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_wait", n < 50, 1);
        d = bus.tx_data;
        check("bp_first_data", d, 8'h61);
        repeat (10) begin
            @(negedge clk);
            check("bp_tx_valid", bus.tx_valid, 1);
            check("bp_tx_data", bus.tx_data, d);
            check("bp_no_ack", bus.req_ack, 0);
        end
        check("bp_ack_count", ack_cnt[1] - a0, 1);
        @(negedge clk);
        bus.tx_ready = 1'b1;
        drain("bp_drain");
        check("bp_acks", ack_cnt[1] - a0, 2);

        // reset after the 2nd of 4 bytes
        a0 = ack_cnt[2];
        x0 = xfers;
        load(2, 8'h71, 0); load(2, 8'h72, 0); load(2, 8'h73, 0); load(2, 8'h74, 1);
        expect_tx(2, 8'h71, 0); expect_tx(2, 8'h72, 0);
        n = 0;
        while (xfers < x0 + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_wait", n < 50, 1);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        rq[2].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_no_ack", ack_cnt[2] - a0, 2);
        load(3, 8'hA0, 1); load(1, 8'hB0, 1);
        expect_tx(1, 8'hB0, 1); expect_tx(3, 8'hA0, 1);
        drain("mid_drain");

        // req3 last byte accepted while req0 waits
        load(3, 8'hC0, 1);
        expect_tx(3, 8'hC0, 1); expect_tx(0, 8'hD0, 1);
        n = 0;
        while (!(bus.gnt_active && bus.gnt_id == 2'd3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("last_grant_wait", n < 50, 1);
        load(0, 8'hD0, 1);
        n = 0;
        while (!bus.pkt_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("last_done_wait", n < 50, 1);
        check("last_done_gnt", bus.gnt_id, 3);
        @(negedge clk);
        check("last_next_gnt", bus.gnt_id, 0);
        check("last_next_active", bus.gnt_active, 1);
        drain("last_drain");

`ifdef UART_ARB_TIMEOUT_EN
        // req1 stalls mid-packet; req2 waits behind it
        load(1, 8'hE0, 0);
        expect_tx(1, 8'hE0, 0); expect_tx(2, 8'hF0, 1);
        n = 0;
        while (!(bus.gnt_active && bus.gnt_id == 2'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_grant_wait", n < 50, 1);
        load(2, 8'hF0, 1);
        n = 0;
        while (!bus.timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_wait", n < 100, 1);
        check("to_gnt_active", bus.gnt_active, 0);
        drain("to_drain");
        check("to_next_gnt", bus.gnt_id, 2);
`else
        check("timeout_tied", bus.timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
